branch_fu: RTL

// - Branch functional unit, directly downstream of the issue stage; one instance per branch FU slot (NUM_FU_BR).
// - Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR and reports taken/target/mispredict to the branch stack.
// - Buffers completed ops, with link values for JAL/JALR, until the CDB arbiter grants a broadcast.
// - Honours squash and branch-mask clear on all in-flight state.

---
 rtl/branch_fu_pkg.sv | 51 +++++
 rtl/branch_fu_br_cond.sv | 46 ++++
 rtl/branch_fu.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/branch_fu_pkg.sv
// Shared types for the branch functional unit: function codes, issue/resolve/CDB packets.
package branch_fu_pkg;

    localparam int XLEN    = 32;
    localparam int BMASK_W = 4;
    localparam int PREG_W  = 6;
    localparam int ROB_W   = 5;
    localparam int BTAG_W  = $clog2(BMASK_W);

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5,
        BR_JAL  = 3'd6,
        BR_JALR = 3'd7
    } BR_FUNC;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    rs1_val;
        logic [XLEN-1:0]    rs2_val;
        BR_FUNC             func;
        logic               pred_taken;
        logic [XLEN-1:0]    pred_target;
        logic [PREG_W-1:0]  dest_preg;
        logic               has_dest;
        logic [ROB_W-1:0]   rob_idx;
        logic [BMASK_W-1:0] bmask;
        logic [BTAG_W-1:0]  btag;
    } BR_ISSUE_PACKET;

    typedef struct packed {
        logic               taken;
        logic [XLEN-1:0]    target;
        logic               mispredict;
        logic [BTAG_W-1:0]  btag;
        logic [ROB_W-1:0]   rob_idx;
    } BR_RESOLVE_PACKET;

    typedef struct packed {
        logic [PREG_W-1:0]  dest_preg;
        logic [XLEN-1:0]    value;
        logic               has_dest;
        logic [ROB_W-1:0]   rob_idx;
    } BR_CDB_PACKET;

endpackage

// File: rtl/branch_fu_br_cond.sv
// Combinational branch evaluation: condition, target, link value and mispredict flag.
module br_cond
    import branch_fu_pkg::*;
(
    input  BR_FUNC          func,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link,
    output logic            mispredict
);

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;

    assign rs1_s = rs1_val;
    assign rs2_s = rs2_val;
    assign link  = pc + XLEN'(4);

    always_comb begin
        taken  = 1'b0;
        target = pc + imm;
        unique case (func)
            BR_BEQ:  taken = (rs1_val == rs2_val);
            BR_BNE:  taken = (rs1_val != rs2_val);
            BR_BLT:  taken = (rs1_s < rs2_s);
            BR_BGE:  taken = (rs1_s >= rs2_s);
            BR_BLTU: taken = (rs1_val < rs2_val);
            BR_BGEU: taken = (rs1_val >= rs2_val);
            BR_JAL:  taken = 1'b1;
            BR_JALR: begin
                taken  = 1'b1;
                // JALR targets are halfword-aligned by clearing bit 0
                target = (rs1_val + imm) & {{(XLEN-1){1'b1}}, 1'b0};
            end
        endcase
    end

    assign mispredict = (taken != pred_taken) || (taken && (target != pred_target));

endmodule

// File: rtl/branch_fu.sv
// Branch FU: resolves branches/jumps, holds completions in an age-ordered buffer until CDB grant.
// Optional BR_FU_STATS_EN adds saturating resolve/mispredict counters.
module branch_fu
    import branch_fu_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  BR_ISSUE_PACKET     in_pkt,
    output logic               in_ready,
    input  logic               squash_valid,
    input  logic [BMASK_W-1:0] squash_bmask,
    input  logic               clear_valid,
    input  logic [BMASK_W-1:0] clear_bmask,
    output logic               resolve_valid,
    output BR_RESOLVE_PACKET   resolve_pkt,
    output logic               cdb_req,
    input  logic               cdb_gnt,
    output BR_CDB_PACKET       cdb_pkt
`ifdef BR_FU_STATS_EN
    ,
    output logic [31:0]        perf_resolved,
    output logic [31:0]        perf_mispred
`endif
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    typedef struct packed {
        BR_CDB_PACKET       cdb;
        logic [BMASK_W-1:0] bmask;
    } buf_entry_t;

    logic               taken_p0;
    logic [XLEN-1:0]    target_p0;
    logic [XLEN-1:0]    link_p0;
    logic               mispredict_p0;
    logic               accept_p0;
    logic               squash_in_p0;
    logic [BMASK_W-1:0] clr_keep;
    BR_RESOLVE_PACKET   resolve_pkt_p0;
    buf_entry_t         new_ent_p0;

    logic               vld_p1;
    BR_RESOLVE_PACKET   resolve_pkt_p1;

    buf_entry_t         ent_q [OUT_DEPTH];
    buf_entry_t         ent_d [OUT_DEPTH];
    logic [OUT_DEPTH-1:0] ent_vld_q;
    logic [OUT_DEPTH-1:0] ent_vld_d;
    logic [OUT_DEPTH-1:0] keep;
    logic [CNT_W-1:0]   count;
    logic               head_kill;
    logic               pop;

    br_cond u_cond (
        .func        (in_pkt.func),
        .pc          (in_pkt.pc),
        .imm         (in_pkt.imm),
        .rs1_val     (in_pkt.rs1_val),
        .rs2_val     (in_pkt.rs2_val),
        .pred_taken  (in_pkt.pred_taken),
        .pred_target (in_pkt.pred_target),
        .taken       (taken_p0),
        .target      (target_p0),
        .link        (link_p0),
        .mispredict  (mispredict_p0)
    );

    // Stage p0: issue-side evaluation and accept decision
    always_comb begin
        count = '0;
        for (int i = 0; i < OUT_DEPTH; i++) begin
            count = count + CNT_W'(ent_vld_q[i]);
        end
    end

    assign in_ready     = (count < CNT_W'(OUT_DEPTH));
    assign accept_p0    = in_valid && in_ready;
    assign squash_in_p0 = squash_valid && |(in_pkt.bmask & squash_bmask);
    assign clr_keep     = clear_valid ? ~clear_bmask : {BMASK_W{1'b1}};

    assign resolve_pkt_p0.taken      = taken_p0;
    assign resolve_pkt_p0.target     = target_p0;
    assign resolve_pkt_p0.mispredict = mispredict_p0;
    assign resolve_pkt_p0.btag       = in_pkt.btag;
    assign resolve_pkt_p0.rob_idx    = in_pkt.rob_idx;

    assign new_ent_p0.cdb.dest_preg = in_pkt.dest_preg;
    assign new_ent_p0.cdb.value     = link_p0;
    assign new_ent_p0.cdb.has_dest  = in_pkt.has_dest;
    assign new_ent_p0.cdb.rob_idx   = in_pkt.rob_idx;
    assign new_ent_p0.bmask         = in_pkt.bmask & clr_keep;

    assign head_kill = squash_valid && |(ent_q[0].bmask & squash_bmask);
    assign cdb_req   = ent_vld_q[0] && !head_kill;
    assign pop       = cdb_req && cdb_gnt;
    assign cdb_pkt   = cdb_req ? ent_q[0].cdb : '0;

    // Survivors compact toward slot 0 in age order; the new op lands after them.
    always_comb begin
        int r;
        r         = 0;
        ent_d     = ent_q;
        ent_vld_d = '0;
        for (int i = 0; i < OUT_DEPTH; i++) begin
            keep[i] = ent_vld_q[i]
                   && !(squash_valid && |(ent_q[i].bmask & squash_bmask))
                   && !((i == 0) && pop);
        end
        for (int i = 0; i < OUT_DEPTH; i++) begin
            if (keep[i]) begin
                for (int j = 0; j < OUT_DEPTH; j++) begin
                    if (j == r) begin
                        ent_d[j].cdb   = ent_q[i].cdb;
                        ent_d[j].bmask = ent_q[i].bmask & clr_keep;
                        ent_vld_d[j]   = 1'b1;
                    end
                end
                r = r + 1;
            end
        end
        if (accept_p0 && !squash_in_p0) begin
            for (int j = 0; j < OUT_DEPTH; j++) begin
                if (j == r) begin
                    ent_d[j]     = new_ent_p0;
                    ent_vld_d[j] = 1'b1;
                end
            end
        end
    end

    // Stage p1: registered resolve result and completion buffer
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            ent_vld_q <= '0;
        end else begin
            vld_p1    <= accept_p0 && !squash_in_p0;
            ent_vld_q <= ent_vld_d;
        end
    end

    always_ff @(posedge clock) begin
        resolve_pkt_p1 <= resolve_pkt_p0;
        ent_q          <= ent_d;
    end

    assign resolve_valid = vld_p1;
    assign resolve_pkt   = vld_p1 ? resolve_pkt_p1 : '0;

`ifdef BR_FU_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_resolved <= '0;
            perf_mispred  <= '0;
        end else begin
            perf_resolved <= sat_inc(perf_resolved, vld_p1);
            perf_mispred  <= sat_inc(perf_mispred, vld_p1 && resolve_pkt_p1.mispredict);
        end
    end
`endif

endmodule
